rs_pool: RTL
============

RS_POOL -- requirements
Module: rs_pool

Interface
REQ-001 Parameter NUM_ENTRIES, default 8: reservation-station entries in the shared pool.
REQ-002 Parameter NUM_FU, default 4: FU classes; one issue port per class.
REQ-003 Parameter NUM_CDB, default 2: CDB broadcast channels.
REQ-004 Parameter ROB_TAG_W, default 5: ROB tag width.
REQ-005 Parameter XLEN, default 32: operand width.
REQ-006 Parameter PAYLOAD_W, default 64: opaque decoded-instruction payload width.
REQ-007 clock  in  1  sole clock; one clock, all state updates on the rising edge.
REQ-008 reset  in  1  synchronous, active-high.
REQ-009 dp_valid  in  1  dispatch request.
REQ-010 dp_ready  out  1  at least one free entry.
REQ-011 dp_fu  in  clog2(NUM_FU)  target FU class.
REQ-012 dp_rob_tag  in  ROB_TAG_W  ROB tag of the instruction.
REQ-013 dp_src_tag/dp_src_rdy/dp_src_val  in  2xROB_TAG_W / 2 / 2xXLEN  source tags, ready flags and values.
REQ-014 dp_payload  in  PAYLOAD_W  carried unchanged to issue.
REQ-015 cdb_valid/cdb_tag/cdb_val  in  NUM_CDB / NUM_CDBxROB_TAG_W / NUM_CDBxXLEN  broadcasts.
REQ-016 iss_valid  out  NUM_FU;  iss_ready  in  NUM_FU;  iss_rob_tag/iss_src_val/iss_payload  out  per port.
REQ-017 rob_head  in  ROB_TAG_W  oldest ROB tag (age reference).
REQ-018 squash  in  1;  squash_tag  in  ROB_TAG_W  mispredicted branch tag.
REQ-019 free_count  out  clog2(NUM_ENTRIES+1)  free entries.

Function
REQ-020 dp_ready SHALL be driven only from registered busy bits; a same-cycle issue does not raise it.
REQ-021 On dp_valid&&dp_ready&&!squash the lowest-index free entry SHALL be written at the edge.
REQ-022 A busy source SHALL become ready, with its value captured, at the edge after any cdb_valid[k] with matching tag; if several channels match, the lowest k wins.
REQ-023 An entry SHALL be eligible when it is busy, both sources are ready, and it was not squashed this cycle; earliest iss_valid is the cycle after allocation or wakeup.
REQ-024 Per port, select SHALL pick one eligible entry of matching dp_fu; iss_* SHALL hold stable while iss_valid&&!iss_ready.
REQ-025 Entry SHALL be freed at the edge where iss_valid&&iss_ready.
REQ-026 Age = (tag - rob_head) mod 2^ROB_TAG_W; squash SHALL free every entry with age > age(squash_tag), wrap-around included, and drop a same-cycle dispatch.
REQ-027 iss_valid SHALL be forced low for entries being squashed in that cycle.
REQ-028 Full: dp_ready=0, dispatch ignored; empty: iss_valid=0, free_count=NUM_ENTRIES.

Reset
REQ-029 reset SHALL clear all busy/ready bits; outputs reset to dp_ready=1, iss_valid=0, free_count=NUM_ENTRIES, data outputs 0.
REQ-030 reset SHALL override dispatch, wakeup, issue and squash in the same cycle.

Configuration
REQ-031 RS_POOL_AGE_SELECT_EN defined: select picks the oldest eligible entry by age.
REQ-032 Undefined: select picks the lowest-index eligible entry; rob_head used only for squash.

Structure
REQ-033 ROB_TAG, RS_POOL_ENTRY struct and the age function SHALL live in the shared sys_defs package.
REQ-034 One sub-module rs_pool_select (one instance per FU port) SHALL implement the picker.

Verification
REQ-035 Dispatch tag 3, both sources ready, fu 1 -> iss_valid[1]=1 next cycle, iss_rob_tag=3; iss_ready=1 -> free_count returns to 8.
REQ-036 Dispatch src0 tag 7 not ready; cdb0 and cdb1 both tag 7 (values 0xA, 0xB) -> issue one cycle later with src0=0xA.
REQ-037 Fill 8 entries -> dp_ready=0; ninth dispatch ignored; one issue handshake -> dp_ready=1 next cycle.
REQ-038 rob_head=30, entries tags 31, 0, 2, squash_tag=31 -> tags 0 and 2 freed, 31 kept.
REQ-039 With AGE_SELECT_EN, rob_head=30, eligible tags 1 (entry 0) and 31 (entry 5) -> tag 31 issued first; without -> tag 1 first.
REQ-040 iss_ready=0 for 3 cycles then 1 -> iss_* stable throughout, single handshake; reset mid-stall -> iss_valid=0 next cycle.

Source files
------------

// File: rtl/sys_defs.sv
// sys_defs -- shared definitions for the reservation-station pool.
//
// Contents:
//   ROB_TAG        reorder-buffer tag type
//   RS_POOL_ENTRY  one reservation-station slot (busy, FU class, tags,
//                  source ready flags/values, opaque payload)
//   rob_age()      distance of a tag from the ROB head, modulo 2^tag width
//
// The SYS_* widths are the widths the entry struct is built with.
// rs_pool's parameters default to them and must be kept equal to them.
package sys_defs;

    localparam int SYS_ROB_TAG_W = 5;
    localparam int SYS_XLEN      = 32;
    localparam int SYS_PAYLOAD_W = 64;
    localparam int SYS_FU_W      = 2;

    typedef logic [SYS_ROB_TAG_W-1:0] ROB_TAG;

    typedef struct packed {
        logic                          busy;
        logic [SYS_FU_W-1:0]           fu;
        ROB_TAG                        rob_tag;
        logic [1:0]                    src_rdy;
        ROB_TAG [1:0]                  src_tag;
        logic [1:0][SYS_XLEN-1:0]      src_val;
        logic [SYS_PAYLOAD_W-1:0]      payload;
    } RS_POOL_ENTRY;

    // Age 0 is the ROB head; larger age means younger. Unsigned wrap of
    // the subtraction gives the modulo for free.
    function automatic ROB_TAG rob_age(input ROB_TAG tag, input ROB_TAG head);
        return tag - head;
    endfunction

endpackage

// File: rtl/rs_pool_select.sv
// rs_pool_select -- issue picker for one FU port of rs_pool.
//
// Config macro: RS_POOL_AGE_SELECT_EN
//   defined   -> pick the eligible entry with the smallest age (oldest)
//   undefined -> pick the lowest-index eligible entry
//
// Ports:
//   clock, reset  rising-edge clock, synchronous active-high reset
//   eligible      per-entry eligibility for this port (already FU-filtered
//                 and squash-masked by the pool)
//   age           per-entry age (only with RS_POOL_AGE_SELECT_EN)
//   iss_ready     port handshake ready
//   valid, idx    chosen entry
//
// Handshake: an offered entry (valid=1) is transferred on the rising edge
// where valid && iss_ready; while valid && !iss_ready the same entry keeps
// being offered so the issue outputs stay stable, even if a lower-index or
// older entry becomes eligible meanwhile.
module rs_pool_select
    import sys_defs::*;
#(
    parameter  int NUM_ENTRIES = 8,
    localparam int IDX_W       = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NUM_ENTRIES-1:0] eligible,
`ifdef RS_POOL_AGE_SELECT_EN
    input  ROB_TAG [NUM_ENTRIES-1:0] age,
`endif
    input  logic                   iss_ready,
    output logic                   valid,
    output logic [IDX_W-1:0]       idx
);

    logic             hold_valid;
    logic [IDX_W-1:0] hold_idx;
    logic             pick_valid;
    logic [IDX_W-1:0] pick_idx;
`ifdef RS_POOL_AGE_SELECT_EN
    ROB_TAG           best_age;
`endif

    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
`ifdef RS_POOL_AGE_SELECT_EN
        best_age   = '1;
        // Strict compare keeps the lower index on a tie.
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (eligible[i] && (!pick_valid || age[i] < best_age)) begin
                pick_valid = 1'b1;
                pick_idx   = IDX_W'(i);
                best_age   = age[i];
            end
        end
`else
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                pick_valid = 1'b1;
                pick_idx   = IDX_W'(i);
            end
        end
`endif
        // A stalled offer wins as long as that entry is still eligible;
        // a squash removes eligibility and so releases the hold.
        if (hold_valid && eligible[hold_idx]) begin
            pick_valid = 1'b1;
            pick_idx   = hold_idx;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            hold_valid <= 1'b0;
            hold_idx   <= '0;
        end else begin
            hold_valid <= pick_valid && !iss_ready;
            hold_idx   <= pick_idx;
        end
    end

    assign valid = pick_valid;
    assign idx   = pick_idx;

endmodule

// File: rtl/rs_pool.sv
// rs_pool -- shared reservation-station pool with per-FU-class issue ports.
//
// Config macro: RS_POOL_AGE_SELECT_EN (oldest-first select; default is
// lowest-index select, rob_head then only matters for squash).
//
// Ports:
//   clock, reset                     rising-edge clock, sync active-high reset
//   dp_valid/dp_ready                dispatch handshake
//   dp_fu, dp_rob_tag                target FU class, ROB tag
//   dp_src_tag/dp_src_rdy/dp_src_val two source operands
//   dp_payload                       opaque, carried to issue unchanged
//   cdb_valid/cdb_tag/cdb_val        result broadcasts (lowest channel wins)
//   iss_valid/iss_ready              per-FU issue handshake
//   iss_rob_tag/iss_src_val/iss_payload  per-FU issue data (0 when idle)
//   rob_head                         oldest ROB tag, age reference
//   squash, squash_tag               flush everything younger than squash_tag
//   free_count                       number of free entries
//
// Handshakes (dispatch and every issue port): a transfer happens on the
// rising edge where valid && ready. dp_ready depends only on registered busy
// bits. iss_* hold stable while iss_valid && !iss_ready, except that a
// squash of the offered entry drops iss_valid in that same cycle.
module rs_pool
    import sys_defs::*;
#(
    parameter int NUM_ENTRIES = 8,
    parameter int NUM_FU      = 4,
    parameter int NUM_CDB     = 2,
    parameter int ROB_TAG_W   = SYS_ROB_TAG_W,
    parameter int XLEN        = SYS_XLEN,
    parameter int PAYLOAD_W   = SYS_PAYLOAD_W,
    localparam int FU_W       = (NUM_FU > 1) ? $clog2(NUM_FU) : 1,
    localparam int IDX_W      = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1,
    localparam int CNT_W      = $clog2(NUM_ENTRIES + 1)
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic                                  dp_valid,
    output logic                                  dp_ready,
    input  logic [FU_W-1:0]                       dp_fu,
    input  logic [ROB_TAG_W-1:0]                  dp_rob_tag,
    input  logic [1:0][ROB_TAG_W-1:0]             dp_src_tag,
    input  logic [1:0]                            dp_src_rdy,
    input  logic [1:0][XLEN-1:0]                  dp_src_val,
    input  logic [PAYLOAD_W-1:0]                  dp_payload,
    input  logic [NUM_CDB-1:0]                    cdb_valid,
    input  logic [NUM_CDB-1:0][ROB_TAG_W-1:0]     cdb_tag,
    input  logic [NUM_CDB-1:0][XLEN-1:0]          cdb_val,
    output logic [NUM_FU-1:0]                     iss_valid,
    input  logic [NUM_FU-1:0]                     iss_ready,
    output logic [NUM_FU-1:0][ROB_TAG_W-1:0]      iss_rob_tag,
    output logic [NUM_FU-1:0][1:0][XLEN-1:0]      iss_src_val,
    output logic [NUM_FU-1:0][PAYLOAD_W-1:0]      iss_payload,
    input  logic [ROB_TAG_W-1:0]                  rob_head,
    input  logic                                  squash,
    input  logic [ROB_TAG_W-1:0]                  squash_tag,
    output logic [CNT_W-1:0]                      free_count
);

    RS_POOL_ENTRY entries [NUM_ENTRIES];
    RS_POOL_ENTRY nxt     [NUM_ENTRIES];
    RS_POOL_ENTRY new_entry;

    logic [NUM_ENTRIES-1:0]             squash_hit;
    logic [NUM_ENTRIES-1:0]             issue_clr;
    logic [NUM_FU-1:0][NUM_ENTRIES-1:0] elig;
    logic [NUM_FU-1:0]                  sel_valid;
    logic [NUM_FU-1:0][IDX_W-1:0]       sel_idx;
    logic                               alloc_found;
    logic [IDX_W-1:0]                   alloc_idx;
    logic [CNT_W-1:0]                   free_cnt;
    logic                               dp_fire;

    // Allocation and occupancy, from registered busy bits only.
    always_comb begin
        alloc_found = 1'b0;
        alloc_idx   = '0;
        free_cnt    = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (!entries[i].busy) begin
                alloc_found = 1'b1;
                alloc_idx   = IDX_W'(i);
                free_cnt    = free_cnt + CNT_W'(1);
            end
        end
    end

    assign dp_ready   = alloc_found;
    assign free_count = free_cnt;
    assign dp_fire    = dp_valid && dp_ready && !squash;

    // Squash frees entries strictly younger than the mispredicted branch.
    always_comb begin
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            squash_hit[i] = squash && entries[i].busy &&
                (rob_age(entries[i].rob_tag, rob_head) > rob_age(squash_tag, rob_head));
        end
    end

    // Incoming entry; a broadcast in the dispatch cycle is captured too,
    // otherwise that wakeup would be lost.
    always_comb begin
        new_entry         = '0;
        new_entry.busy    = 1'b1;
        new_entry.fu      = dp_fu;
        new_entry.rob_tag = dp_rob_tag;
        new_entry.src_tag = dp_src_tag;
        new_entry.payload = dp_payload;
        for (int s = 0; s < 2; s++) begin
            new_entry.src_rdy[s] = dp_src_rdy[s];
            new_entry.src_val[s] = dp_src_val[s];
            if (!dp_src_rdy[s]) begin
                // Descending scan: the lowest matching channel is applied last.
                for (int k = NUM_CDB - 1; k >= 0; k--) begin
                    if (cdb_valid[k] && cdb_tag[k] == dp_src_tag[s]) begin
                        new_entry.src_rdy[s] = 1'b1;
                        new_entry.src_val[s] = cdb_val[k];
                    end
                end
            end
        end
    end

    // Per-port eligibility: busy, both sources ready, right class, not squashed.
    always_comb begin
        for (int p = 0; p < NUM_FU; p++) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                elig[p][i] = entries[i].busy && (&entries[i].src_rdy) &&
                             !squash_hit[i] && (entries[i].fu == SYS_FU_W'(p));
            end
        end
    end

    for (genvar p = 0; p < NUM_FU; p++) begin : g_port
`ifdef RS_POOL_AGE_SELECT_EN
        ROB_TAG [NUM_ENTRIES-1:0] ages;
        always_comb begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                ages[i] = rob_age(entries[i].rob_tag, rob_head);
            end
        end
`endif
        rs_pool_select #(
            .NUM_ENTRIES (NUM_ENTRIES)
        ) u_select (
            .clock     (clock),
            .reset     (reset),
            .eligible  (elig[p]),
`ifdef RS_POOL_AGE_SELECT_EN
            .age       (ages),
`endif
            .iss_ready (iss_ready[p]),
            .valid     (sel_valid[p]),
            .idx       (sel_idx[p])
        );
    end

    // Issue outputs, zeroed when a port has nothing to offer.
    always_comb begin
        for (int p = 0; p < NUM_FU; p++) begin
            iss_valid[p]   = sel_valid[p];
            iss_rob_tag[p] = '0;
            iss_src_val[p] = '0;
            iss_payload[p] = '0;
            if (sel_valid[p]) begin
                iss_rob_tag[p] = entries[sel_idx[p]].rob_tag;
                iss_src_val[p] = entries[sel_idx[p]].src_val;
                iss_payload[p] = entries[sel_idx[p]].payload;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            issue_clr[i] = 1'b0;
            for (int p = 0; p < NUM_FU; p++) begin
                if (sel_valid[p] && iss_ready[p] && sel_idx[p] == IDX_W'(i)) begin
                    issue_clr[i] = 1'b1;
                end
            end
        end
    end

    // Next state per entry: free > wakeup > allocate (allocation only ever
    // targets an entry that is not busy, so the cases never overlap).
    always_comb begin
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            nxt[i] = entries[i];
            if (squash_hit[i] || issue_clr[i]) begin
                nxt[i].busy    = 1'b0;
                nxt[i].src_rdy = '0;
            end else if (entries[i].busy) begin
                for (int s = 0; s < 2; s++) begin
                    if (!entries[i].src_rdy[s]) begin
                        for (int k = NUM_CDB - 1; k >= 0; k--) begin
                            if (cdb_valid[k] && cdb_tag[k] == entries[i].src_tag[s]) begin
                                nxt[i].src_rdy[s] = 1'b1;
                                nxt[i].src_val[s] = cdb_val[k];
                            end
                        end
                    end
                end
            end else if (dp_fire && alloc_idx == IDX_W'(i)) begin
                nxt[i] = new_entry;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                entries[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                entries[i] <= nxt[i];
            end
        end
    end

endmodule
